// File: rtl/pipe_pack_if.sv
// Narrow-in / wide-out handshake bundle for pipe_pack.
// slave is the packer's view; master is the driver/consumer side.
interface pipe_pack_if #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned RATIO = 4
);
  logic                   in_vld;
  logic [DSIZE-1:0]       in_data;
  logic                   pack_empty;
  logic                   flush;
  logic                   out_vld;
  logic [DSIZE*RATIO-1:0] out_data;
  logic [3:0]             out_lanes;
  logic                   out_ready;

  modport slave (
    input  in_vld, in_data, flush, out_ready,
    output pack_empty, out_vld, out_data, out_lanes
  );

  modport master (
    output in_vld, in_data, flush, out_ready,
    input  pack_empty, out_vld, out_data, out_lanes
  );
endinterface

// File: rtl/pipe_pack.sv
// Packs RATIO narrow words into one wide word, lane 0 in the LSBs.
// A flush pulse emits a partially filled word with its lane count.
module pipe_pack #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned RATIO = 4
) (
  input logic        clock,
  input logic        rst,
  pipe_pack_if.slave bus
);
  localparam int unsigned CntW = $clog2(RATIO);
  localparam int unsigned OutW = DSIZE * RATIO;

  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [RATIO-2:0][DSIZE-1:0] acc_q, acc_d;
  logic                        flush_pend_q, flush_pend_d;
  logic                        out_vld_q, out_vld_d;
  logic [OutW-1:0]             out_data_q, out_data_d;
  logic [3:0]                  out_lanes_q, out_lanes_d;

  logic cnt_last, out_free, pack_empty, accept, flush_exec;

  always_comb begin
    cnt_last   = (cnt_q == CntW'(RATIO - 1));
    out_free   = ~out_vld_q | bus.out_ready;
    // Deliberately independent of in_vld so upstream can use it as a ready.
    pack_empty = ~rst & ~flush_pend_q & (~cnt_last | out_free);
    accept     = bus.in_vld & pack_empty;
    flush_exec = flush_pend_q & out_free;
  end

  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    flush_pend_d = flush_pend_q | bus.flush;
    out_vld_d    = out_vld_q & ~bus.out_ready;
    out_data_d   = out_data_q;
    out_lanes_d  = out_lanes_q;

    if (accept) begin
      if (cnt_last) begin
        out_data_d  = {bus.in_data, acc_q};
        out_lanes_d = 4'(RATIO);
        out_vld_d   = 1'b1;
        cnt_d       = '0;
        acc_d       = '0;
      end else begin
        acc_d[cnt_q] = bus.in_data;
        cnt_d        = cnt_q + CntW'(1);
      end
    end else if (flush_exec) begin
      flush_pend_d = 1'b0;
      if (cnt_q != '0) begin
        // Lanes at and above cnt are already zero in the accumulator.
        out_data_d  = {{DSIZE{1'b0}}, acc_q};
        out_lanes_d = 4'(cnt_q);
        out_vld_d   = 1'b1;
        cnt_d       = '0;
        acc_d       = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      flush_pend_q <= 1'b0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_lanes_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      flush_pend_q <= flush_pend_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_lanes_q  <= out_lanes_d;
    end
  end

  assign bus.pack_empty = pack_empty;
  assign bus.out_vld    = out_vld_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_lanes  = out_lanes_q;
endmodule

// File: tb/tb_pipe_pack.sv
// Directed bench for pipe_pack at DSIZE=8, RATIO=4 with hand-computed expectations.
module tb_pipe_pack;
  logic clock;
  logic rst;
  int   checks;
  int   errors;

  pipe_pack_if #(.DSIZE(8), .RATIO(4)) bus ();

  pipe_pack #(.DSIZE(8), .RATIO(4)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [31:0] data,
                         input logic [3:0] lanes);
    chk({tag, ".vld"}, 32'(bus.out_vld), 32'(vld));
    chk({tag, ".data"}, bus.out_data, data);
    chk({tag, ".lanes"}, 32'(bus.out_lanes), 32'(lanes));
  endtask

  // Present one word that must be accepted this cycle.
  task automatic push(input logic [7:0] d);
    bus.in_vld  = 1'b1;
    bus.in_data = d;
    #1;
    chk("push.pack_empty", 32'(bus.pack_empty), 32'd1);
    tick();
    bus.in_vld = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_vld    = 1'b1;
    bus.in_data   = 8'hEE;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;

    // Reset: inputs ignored, outputs zero, not ready.
    tick(); tick(); tick();
    chk("rst.pack_empty", 32'(bus.pack_empty), 32'd0);
    chk_out("rst", 1'b0, 32'h0, 4'd0);
    rst        = 1'b0;
    bus.in_vld = 1'b0;
    bus.flush  = 1'b0;
    #1;
    chk("post_rst.pack_empty", 32'(bus.pack_empty), 32'd1);

    // Streaming with out_ready high.
    push(8'h11); push(8'h22); push(8'h33);
    chk("stream.no_early_vld", 32'(bus.out_vld), 32'd0);
    push(8'h44);
    chk_out("stream", 1'b1, 32'h44332211, 4'd4);
    chk("stream.pack_empty", 32'(bus.pack_empty), 32'd1);
    tick();
    chk("stream.drained", 32'(bus.out_vld), 32'd0);

    // Backpressure: hold a word, fill three lanes, fourth waits upstream.
    bus.out_ready = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk_out("bp.hold0", 1'b1, 32'h44332211, 4'd4);
    push(8'hA1); push(8'hA2); push(8'hA3);
    bus.in_vld  = 1'b1;
    bus.in_data = 8'hA4;
    #1;
    chk("bp.stall", 32'(bus.pack_empty), 32'd0);
    tick();
    chk_out("bp.hold1", 1'b1, 32'h44332211, 4'd4);
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release", 32'(bus.pack_empty), 32'd1);
    tick();
    bus.in_vld = 1'b0;
    chk_out("bp.next", 1'b1, 32'hA4A3A2A1, 4'd4);
    tick();
    chk("bp.drained", 32'(bus.out_vld), 32'd0);

    // Flush of a two-lane partial word.
    push(8'h55); push(8'h66);
    bus.flush = 1'b1;
    #1;
    chk("fl2.pulse_cycle", 32'(bus.pack_empty), 32'd1);
    tick();
    bus.flush = 1'b0;
    #1;
    chk("fl2.pend", 32'(bus.pack_empty), 32'd0);
    chk("fl2.pend_vld", 32'(bus.out_vld), 32'd0);
    tick();
    chk_out("fl2", 1'b1, 32'h00006655, 4'd2);
    chk("fl2.pend_cleared", 32'(bus.pack_empty), 32'd1);
    tick();
    chk("fl2.drained", 32'(bus.out_vld), 32'd0);

    // Flush with nothing accumulated.
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("fl0.pend", 32'(bus.pack_empty), 32'd0);
    tick();
    chk("fl0.no_vld", 32'(bus.out_vld), 32'd0);
    chk("fl0.cleared", 32'(bus.pack_empty), 32'd1);

    // Flush coinciding with the third accept.
    push(8'h55); push(8'h66);
    bus.in_vld  = 1'b1;
    bus.in_data = 8'h77;
    bus.flush   = 1'b1;
    tick();
    bus.in_vld = 1'b0;
    bus.flush  = 1'b0;
    #1;
    chk("fl3.pend", 32'(bus.pack_empty), 32'd0);
    chk("fl3.pend_vld", 32'(bus.out_vld), 32'd0);
    tick();
    chk_out("fl3", 1'b1, 32'h00776655, 4'd3);
    tick();
    chk("fl3.drained", 32'(bus.out_vld), 32'd0);

    // Reset mid-word discards the partial word.
    push(8'h01); push(8'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid.pack_empty", 32'(bus.pack_empty), 32'd1);
    chk("rst_mid.vld", 32'(bus.out_vld), 32'd0);
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    chk_out("rst_mid.clean", 1'b1, 32'hB4B3B2B1, 4'd4);

    // Reset while a word is held discards it.
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("rst_full", 1'b0, 32'h0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_pack.md
PIPE_PACK -- requirements
Module: pipe_pack

Interface
REQ-001 Parameter DSIZE, default 8, width of one narrow input word.
REQ-002 Parameter RATIO, default 4, narrow words per wide output word; legal range 2..8.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_vld  input  1  upstream word valid; driven by an upstream pipe stage's valid output.
REQ-006 in_data  input  DSIZE  upstream word.
REQ-007 pack_empty  output  1  "can accept" flag; drives the upstream stage's low_empty input.
REQ-008 flush  input  1  single-cycle pulse requesting emission of a partial wide word.
REQ-009 out_vld  output  1  wide word valid.
REQ-010 out_data  output  DSIZE*RATIO  wide word; lane 0 occupies the LSBs.
REQ-011 out_lanes  output  4  count of valid lanes in out_data, 1..RATIO when out_vld=1.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-013 Accept event = in_vld & pack_empty; this is the only condition that consumes in_data.
REQ-014 pack_empty = ~rst & ~flush_pend & ((cnt != RATIO-1) | ~out_vld | out_ready); this is a combinational function of registered state and out_ready only, with no dependence on in_vld.
REQ-015 Internal state: lane counter cnt (0..RATIO-1), accumulator of RATIO-1 lanes, and flush_pend flag.
REQ-016 Accept with cnt < RATIO-1: in_data is written to accumulator lane cnt, and cnt increments by 1.
REQ-017 Accept with cnt = RATIO-1 loads the output register on the next edge.
  - out_data is {in_data, accumulator lanes RATIO-2..0}.
  - out_lanes = RATIO.
  - out_vld = 1.
  - cnt = 0 and the accumulator is cleared to 0.
  - Latency from the last narrow word to out_vld is 1 cycle.
REQ-018 Output drain: when out_vld & out_ready and no load occurs in the same cycle, out_vld is 0 on the next edge; out_data and out_lanes hold their values.
REQ-019 Simultaneous drain and load: out_vld stays 1 and the new word replaces the old one with no bubble.
REQ-020 When out_vld=1 and out_ready=0, out_data, out_lanes and out_vld are held stable.
REQ-021 A flush pulse sets flush_pend on the next edge.
  - A flush pulse that arrives while flush_pend=1 has no additional effect.
  - An accept in the same cycle as the flush pulse completes normally before flush_pend takes effect.
REQ-022 Flush execution condition: flush_pend=1 and the output register is free (~out_vld | out_ready).
  - If cnt != 0: out_data is loaded with the accumulator lanes, unused lanes are set to 0, out_lanes = cnt, out_vld = 1, and cnt is set to 0.
  - If cnt = 0: no output is produced.
  - In both cases flush_pend is cleared on the same edge.
REQ-023 While flush_pend=1, pack_empty=0, so no input is accepted.
REQ-024 out_lanes = RATIO for every full word; out_lanes is never 0 while out_vld=1.
REQ-025 The block never drops or duplicates a narrow word, and lane order equals arrival order.

Reset
REQ-026 While rst=1, on every edge the following values are applied:
  - out_vld = 0
  - out_data = 0
  - out_lanes = 0
  - cnt = 0
  - accumulator = 0
  - flush_pend = 0
REQ-027 While rst=1, pack_empty=0; in_vld and flush are ignored.
REQ-028 Reset asserted mid-word discards the partial accumulator without emitting it.
REQ-029 Reset asserted while out_vld=1 discards the output word.
REQ-030 In the first cycle after rst deasserts, pack_empty=1.

Verification (DSIZE=8, RATIO=4)
REQ-031 Streaming, out_ready=1: in_data 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle after 0x44, out_vld=1, out_data=0x44332211, out_lanes=4; pack_empty stays 1 throughout.
REQ-032 Backpressure with out_ready=0 holding word 0x44332211 -> 0xA1,0xA2,0xA3 are accepted, pack_empty falls to 0 with cnt=3, and 0xA4 is held upstream; when out_ready=1, 0xA4 is accepted that cycle and the next word is 0xA4A3A2A1 with no bubble.
REQ-033 Flush after 0x55,0x66 -> out_data=0x00006655, out_lanes=2; pack_empty=0 for exactly the flush_pend cycle.
REQ-034 Flush with cnt=0 and the output empty -> no out_vld, and flush_pend clears after 1 cycle.
REQ-035 Flush in the same cycle as accept of the 3rd word 0x77 (after 0x55,0x66) -> out_data=0x00776655, out_lanes=3.
REQ-036 rst pulsed after 2 words accepted -> no output; the next 4 words form a clean word with out_lanes=4.
